// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor working on BPC-bit slices per clock,
// least-significant slice first, with one carry/borrow flop linking the slices.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / BPC;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(N - 1);

  if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_badParams
    $error("serial_addsub: WIDTH must be >= 2 and an exact multiple of BPC");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [SW-1:0]    step_q;
  logic             carry_q;
  logic [WIDTH-1:0] aLat_q;
  logic [WIDTH-1:0] bLat_q;
  logic             modeLat_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  int               sliceBase;
  logic [BPC-1:0]   aSlice;
  logic [BPC-1:0]   bSlice;
  logic [BPC-1:0]   sliceSum;
  logic             chainC;
  logic             carry_d;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_d;

  // Ripple the current slice through per-bit full-adder / full-subtractor cells.
  always_comb begin
    sliceBase = int'(step_q) * BPC;
    aSlice    = aLat_q[sliceBase +: BPC];
    bSlice    = bLat_q[sliceBase +: BPC];
    chainC    = carry_q;
    sliceSum  = '0;
    for (int i = 0; i < BPC; i++) begin
      sliceSum[i] = aSlice[i] ^ bSlice[i] ^ chainC;
      if (modeLat_q) begin
        chainC = (~aSlice[i] & bSlice[i]) | (~(aSlice[i] ^ bSlice[i]) & chainC);
      end else begin
        chainC = (aSlice[i] & bSlice[i]) | (chainC & (aSlice[i] ^ bSlice[i]));
      end
    end
    carry_d = chainC;
    acc_d   = acc_q;
    acc_d[sliceBase +: BPC] = sliceSum;
    if (modeLat_q) begin
      ovf_d = (aLat_q[WIDTH-1] != bLat_q[WIDTH-1]) && (acc_d[WIDTH-1] != aLat_q[WIDTH-1]);
    end else begin
      ovf_d = (aLat_q[WIDTH-1] == bLat_q[WIDTH-1]) && (acc_d[WIDTH-1] != aLat_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      carry_q   <= 1'b0;
      aLat_q    <= '0;
      bLat_q    <= '0;
      modeLat_q <= 1'b0;
      acc_q     <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          carry_q <= carry_d;
          acc_q   <= acc_d;
          if (step_q == LAST_STEP) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= acc_d;
            cout_q   <= carry_d;
            ovf_q    <= ovf_d;
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation; DONE gives back-to-back.
          done_q <= 1'b0;
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            step_q    <= '0;
            carry_q   <= 1'b0;
            acc_q     <= '0;
            aLat_q    <= a;
            bLat_q    <= b;
            modeLat_q <= mode;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench driving three serial_addsub configurations
// (8/1, 4/2, 4/4); monitors pop expected responses whenever done is seen.
module tb_serial_addsub;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       o;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic       start4 = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic       busy8, done8, cout8, ovf8;
  logic [7:0] result8;
  logic       busy42, done42, cout42, ovf42;
  logic [3:0] result42;
  logic       busy44, done44, cout44, ovf44;
  logic [3:0] result44;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q42[$];
  exp_t q44[$];
  exp_t e8, e42, e44;

  serial_addsub #(.WIDTH(8), .BPC(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode), .a(a), .b(b),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(4), .BPC(2)) dut42 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .a(a[3:0]), .b(b[3:0]),
    .busy(busy42), .done(done42), .result(result42), .cout(cout42), .ovf(ovf42)
  );

  serial_addsub #(.WIDTH(4), .BPC(4)) dut44 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .a(a[3:0]), .b(b[3:0]),
    .busy(busy44), .done(done44), .result(result44), .cout(cout44), .ovf(ovf44)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arithmetic reference for a w-bit operation, independent of the bit-cell chain.
  function automatic exp_t model(input int w, input bit m, input logic [7:0] aa, input logic [7:0] bb);
    exp_t e;
    int mask, x, y, full, aS, bS, rS;
    mask  = (1 << w) - 1;
    x     = int'(aa) & mask;
    y     = int'(bb) & mask;
    full  = m ? (x - y) : (x + y);
    e.res = 8'(full & mask);
    e.c   = m ? (x < y) : (((full >> w) & 1) != 0);
    aS    = (x >> (w - 1)) & 1;
    bS    = (y >> (w - 1)) & 1;
    rS    = ((full & mask) >> (w - 1)) & 1;
    e.o   = m ? (aS != bS && rS != aS) : (aS == bS && rS != aS);
    e.cyc = 0;
    return e;
  endfunction

  // Called at a negedge; asserts start for one edge and returns at the next negedge.
  task automatic applyStimulus(input bit s8, input bit s4, input bit push, input bit m,
                               input logic [7:0] aa, input logic [7:0] bb,
                               input logic [7:0] r8, input bit c8, input bit o8);
    exp_t e;
    mode   = m;
    a      = aa;
    b      = bb;
    start8 = s8;
    start4 = s4;
    if (push && s8) begin
      e.res = r8; e.c = c8; e.o = o8; e.cyc = cyc + 1 + 8;
      q8.push_back(e);
    end
    if (push && s4) begin
      e = model(4, m, aa, bb);
      e.cyc = cyc + 1 + 2;
      q42.push_back(e);
      e.cyc = cyc + 1 + 1;
      q44.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic waitDone8();
    int n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done8) checkOutput("w8 done timeout", 32'(done8), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        checkOutput("w8 unexpected done", 32'(done8), 32'd0);
      end else begin
        e8 = q8.pop_front();
        checkOutput("w8 result", 32'(result8), 32'(e8.res));
        checkOutput("w8 cout", 32'(cout8), 32'(e8.c));
        checkOutput("w8 ovf", 32'(ovf8), 32'(e8.o));
        checkOutput("w8 latency", cyc, e8.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done42) begin
      if (q42.size() == 0) begin
        checkOutput("w4b2 unexpected done", 32'(done42), 32'd0);
      end else begin
        e42 = q42.pop_front();
        checkOutput("w4b2 result", 32'(result42), 32'(e42.res));
        checkOutput("w4b2 cout", 32'(cout42), 32'(e42.c));
        checkOutput("w4b2 ovf", 32'(ovf42), 32'(e42.o));
        checkOutput("w4b2 latency", cyc, e42.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done44) begin
      if (q44.size() == 0) begin
        checkOutput("w4b4 unexpected done", 32'(done44), 32'd0);
      end else begin
        e44 = q44.pop_front();
        checkOutput("w4b4 result", 32'(result44), 32'(e44.res));
        checkOutput("w4b4 cout", 32'(cout44), 32'(e44.c));
        checkOutput("w4b4 ovf", 32'(ovf44), 32'(e44.o));
        checkOutput("w4b4 latency", cyc, e44.cyc);
      end
    end
  end

  initial begin
    int n;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset w8 busy/done", {busy8, done8}, 2'b00);
    checkOutput("reset w8 result/cout/ovf", {result8, cout8, ovf8}, 10'd0);
    checkOutput("reset w4 busy/done", {busy42, done42, busy44, done44}, 4'b0000);
    checkOutput("reset w4 result/cout/ovf", {result42, cout42, ovf42, result44, cout44, ovf44}, 12'd0);

    $display("[TB] add with signed overflow, busy window");
    applyStimulus(1, 0, 1, 0, 8'h3C, 8'h45, 8'h81, 0, 1);
    n = 0;
    while (busy8 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("w8 busy cycles", n, 8);
    checkOutput("w8 done after busy", 32'(done8), 32'd1);
    @(negedge clk);

    $display("[TB] subtract cases");
    applyStimulus(1, 0, 1, 1, 8'h10, 8'h20, 8'hF0, 1, 0);
    waitDone8();
    @(negedge clk);
    applyStimulus(1, 0, 1, 1, 8'h80, 8'h01, 8'h7F, 0, 1);
    waitDone8();
    @(negedge clk);

    $display("[TB] wrap-around then back-to-back start in DONE");
    applyStimulus(1, 0, 1, 0, 8'hFF, 8'h01, 8'h00, 1, 0);
    waitDone8();
    checkOutput("w8 busy in DONE", 32'(busy8), 32'd0);
    applyStimulus(1, 0, 1, 1, 8'h05, 8'h05, 8'h00, 0, 0);
    checkOutput("w8 busy after back-to-back", 32'(busy8), 32'd1);
    waitDone8();
    @(negedge clk);

    $display("[TB] start pulses during RUN are ignored");
    applyStimulus(1, 0, 1, 1, 8'h20, 8'h90, 8'h90, 1, 1);
    applyStimulus(1, 0, 0, 0, 8'h01, 8'h01, 8'h00, 0, 0);
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 8'hFF, 8'hFF, 8'h00, 0, 0);
    waitDone8();
    repeat (12) @(negedge clk);

    $display("[TB] reset aborts an operation at step 4");
    applyStimulus(1, 0, 0, 0, 8'h11, 8'h22, 8'h00, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy/done", {busy8, done8}, 2'b00);
    checkOutput("abort result/cout/ovf", {result8, cout8, ovf8}, 10'd0);
    repeat (12) @(negedge clk);
    applyStimulus(1, 0, 1, 0, 8'h7F, 8'h7F, 8'hFE, 0, 1);
    waitDone8();
    @(negedge clk);

    $display("[TB] exhaustive WIDTH=4 with BPC=2 and BPC=4");
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          applyStimulus(0, 1, 1, m[0], 8'(x), 8'(y), 8'h00, 0, 0);
          repeat (2) @(negedge clk);
        end
      end
    end

    n = 0;
    while ((q8.size() + q42.size() + q44.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pending responses", q8.size() + q42.size() + q44.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
